// File: rtl/quick_spi_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : quick_spi_pkg
// Desc     : Shared SPI constants, mode encodings and slave state encoding
// Revision : 1.0 - initial release
// ==========================================================================
package quick_spi_pkg;

  localparam bit MSB_FIRST = 1'b1;
  localparam bit LSB_FIRST = 1'b0;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/quick_spi_sync_edge.sv
`default_nettype none
// ==========================================================================
// Module   : quick_spi_sync_edge
// Desc     : Multi-stage synchronizer with rise/fall detection on the output
// Revision : 1.0 - initial release
// ==========================================================================
module quick_spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VALUE}};
      r_prev <= RESET_VALUE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign rise   = w_sync & ~r_prev;
  assign fall   = ~w_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/quick_spi_slave.sv
`default_nettype none
// ==========================================================================
// Module   : quick_spi_slave
// Desc     : Oversampling SPI responder, all CPOL/CPHA modes, both bit orders
// Macro    : QUICK_SPI_SLAVE_UNDERRUN_EN builds the sticky tx_underrun flag
// Revision : 1.0 - initial release
// ==========================================================================
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter bit BITS_ORDER      = MSB_FIRST,
  parameter bit CPOL            = 1'b0,
  parameter bit CPHA            = 1'b0,
  parameter bit MISO_IDLE_VALUE = 1'b0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  end_of_transaction,
  output logic                  tx_underrun
);

  localparam int               CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0]       C_MODE     = {CPOL, CPHA};
  localparam bit               C_CPOL     = (C_MODE == SPI_MODE2) || (C_MODE == SPI_MODE3);
  localparam bit               C_CPHA     = (C_MODE == SPI_MODE1) || (C_MODE == SPI_MODE3);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DATA_WIDTH);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_full;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    r_miso;
  logic                    r_miso_oe;
  logic                    r_busy;
  logic                    r_eot;
  logic                    r_skip_shift;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;

  logic                    w_sclk_rise;
  logic                    w_sclk_fall;
  logic                    w_ss_rise;
  logic                    w_ss_fall;
  logic                    w_mosi;
  logic                    w_sample_edge;
  logic                    w_shift_edge;
  logic                    w_start;
  logic                    w_wrap;
  logic                    w_reload;
  logic [DATA_WIDTH-1:0]   w_load_word;
  logic                    w_load_head;
  logic [DATA_WIDTH-1:0]   w_load_shifted;
  logic                    w_tx_head;
  logic [DATA_WIDTH-1:0]   w_tx_shifted;
  logic [DATA_WIDTH-1:0]   w_rx_next;

  quick_spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (CPOL)
  ) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sclk),
    .rise    (w_sclk_rise),
    .fall    (w_sclk_fall)
  );

  // History resets low so a select held low through reset never looks like a fall
  quick_spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_ss_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ss_n),
    .rise    (w_ss_rise),
    .fall    (w_ss_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample_edge = C_CPHA ? (C_CPOL ? w_sclk_rise : w_sclk_fall)
                                : (C_CPOL ? w_sclk_fall : w_sclk_rise);
  assign w_shift_edge  = C_CPHA ? (C_CPOL ? w_sclk_fall : w_sclk_rise)
                                : (C_CPOL ? w_sclk_rise : w_sclk_fall);

  assign w_start     = (r_state == IDLE) && w_ss_fall && enable;
  assign w_wrap      = (r_state == ACTIVE) && !w_ss_rise && (r_bit_cnt == C_CNT_FULL);
  assign w_reload    = w_start || w_wrap;
  assign w_load_word = r_hold_full ? r_hold : '0;

  generate
    if (BITS_ORDER == LSB_FIRST) begin : g_lsb_first
      assign w_rx_next      = {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
      assign w_tx_head      = r_tx_shift[0];
      assign w_tx_shifted   = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
      assign w_load_head    = w_load_word[0];
      assign w_load_shifted = {1'b0, w_load_word[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_rx_next      = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
      assign w_tx_head      = r_tx_shift[DATA_WIDTH-1];
      assign w_tx_shifted   = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      assign w_load_head    = w_load_word[DATA_WIDTH-1];
      assign w_load_shifted = {w_load_word[DATA_WIDTH-2:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_miso       <= MISO_IDLE_VALUE;
      r_miso_oe    <= 1'b0;
      r_busy       <= 1'b0;
      r_eot        <= 1'b0;
      r_skip_shift <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_eot      <= 1'b0;

      // A reload reads the old holding content, so a same-cycle load feeds the next word
      if (tx_load) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state      <= ACTIVE;
            r_busy       <= 1'b1;
            r_miso_oe    <= 1'b1;
            r_bit_cnt    <= '0;
            r_skip_shift <= 1'b0;
            if (!C_CPHA) begin
              r_miso     <= w_load_head;
              r_tx_shift <= w_load_shifted;
            end else begin
              r_tx_shift <= w_load_word;
            end
          end
        end

        ACTIVE: begin
          if (w_ss_rise) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_miso       <= MISO_IDLE_VALUE;
            r_eot        <= 1'b1;
            r_bit_cnt    <= '0;
            r_skip_shift <= 1'b0;
          end else begin
            if (w_sample_edge) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
            if (w_wrap) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              if (!C_CPHA) begin
                r_miso       <= w_load_head;
                r_tx_shift   <= w_load_shifted;
                r_skip_shift <= 1'b1;
              end else begin
                r_tx_shift <= w_load_word;
              end
            end else if (w_shift_edge) begin
              if (r_skip_shift) begin
                r_skip_shift <= 1'b0;
              end else begin
                r_miso     <= w_tx_head;
                r_tx_shift <= w_tx_shifted;
              end
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef QUICK_SPI_SLAVE_UNDERRUN_EN
  logic r_tx_underrun;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_underrun <= 1'b0;
    end else if (tx_load) begin
      r_tx_underrun <= 1'b0;
    end else if (w_reload && !r_hold_full) begin
      r_tx_underrun <= 1'b1;
    end
  end

  assign tx_underrun = r_tx_underrun;
`else
  assign tx_underrun = 1'b0;
`endif

  assign miso               = r_miso;
  assign miso_oe            = r_miso_oe;
  assign rx_data            = r_rx_data;
  assign rx_valid           = r_rx_valid;
  assign tx_ready           = ~r_hold_full;
  assign busy               = r_busy;
  assign end_of_transaction = r_eot;

endmodule
`default_nettype wire

// File: tb/tb_quick_spi_slave.sv
`default_nettype none
// ==========================================================================
// Module   : tb_quick_spi_slave
// Desc     : Scoreboard bench, four slaves (modes 0..3, MSB/LSB/MSB/LSB first)
// Revision : 1.0 - initial release
// ==========================================================================
module tb_quick_spi_slave;

  localparam int HALF = 8;
  localparam int NI   = 4;
`ifdef QUICK_SPI_SLAVE_UNDERRUN_EN
  localparam bit EXP_UR = 1'b1;
`else
  localparam bit EXP_UR = 1'b0;
`endif

  typedef struct {
    int         inst;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NI-1:0] sclk;
  logic [NI-1:0] ss_n;
  logic          mosi;
  logic [NI-1:0] miso, miso_oe, rx_valid, tx_load, tx_ready, busy, eot, tx_underrun;
  logic [7:0]    rx_data [NI];
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      quick_spi_slave #(
        .DATA_WIDTH      (8),
        .BITS_ORDER      ((g == 1 || g == 3) ? 1'b0 : 1'b1),
        .CPOL            (g >= 2),
        .CPHA            (g % 2 == 1),
        .MISO_IDLE_VALUE (1'b0),
        .SYNC_STAGES     (2)
      ) u_dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .sclk               (sclk[g]),
        .ss_n               (ss_n[g]),
        .mosi               (mosi),
        .miso               (miso[g]),
        .miso_oe            (miso_oe[g]),
        .rx_data            (rx_data[g]),
        .rx_valid           (rx_valid[g]),
        .tx_data            (tx_data),
        .tx_load            (tx_load[g]),
        .tx_ready           (tx_ready[g]),
        .busy               (busy[g]),
        .end_of_transaction (eot[g]),
        .tx_underrun        (tx_underrun[g])
      );
    end
  endgenerate

  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  int         eot_cnt [NI];
  logic [7:0] mtx [3];
  logic [7:0] mrx [3];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int m, input logic [7:0] d);
    exp_t e;
    e.inst = m;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic load(input int m, input logic [7:0] d);
    tx_data    = d;
    tx_load[m] = 1'b1;
    wait_clk(1);
    tx_load[m] = 1'b0;
  endtask

  task automatic master_xfer(input int m, input int nbits, input bit do_sel, input bit exp_sel);
    bit cpol, cpha, lsb;
    int w, idx;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    lsb  = (m == 1 || m == 3);
    for (int k = 0; k < 3; k++) mrx[k] = 8'h00;
    if (do_sel) begin
      ss_n[m] = 1'b0;
      wait_clk(HALF);
      check($sformatf("busy_on_select_i%0d", m), busy[m], exp_sel);
      check($sformatf("oe_on_select_i%0d", m), miso_oe[m], exp_sel);
    end
    for (int b = 0; b < nbits; b++) begin
      w   = b / 8;
      idx = lsb ? (b % 8) : (7 - b % 8);
      if (!cpha) begin
        mosi = mtx[w][idx];
        wait_clk(HALF);
        mrx[w][idx] = miso[m];
        sclk[m] = ~cpol;
        wait_clk(HALF);
        sclk[m] = cpol;
      end else begin
        wait_clk(HALF);
        sclk[m] = ~cpol;
        mosi = mtx[w][idx];
        wait_clk(HALF);
        mrx[w][idx] = miso[m];
        sclk[m] = cpol;
      end
    end
    wait_clk(HALF);
    if (do_sel) begin
      ss_n[m] = 1'b1;
      wait_clk(HALF);
      if (exp_sel) begin
        check($sformatf("miso_idle_i%0d", m), miso[m], 1'b0);
        check($sformatf("oe_idle_i%0d", m), miso_oe[m], 1'b0);
        check($sformatf("busy_idle_i%0d", m), busy[m], 1'b0);
      end
    end
  endtask

  task automatic run_word(input int m, input logic [7:0] slave_tx, input logic [7:0] master_tx);
    int e0;
    load(m, slave_tx);
    push_exp(m, master_tx);
    mtx[0] = master_tx;
    e0 = eot_cnt[m];
    master_xfer(m, 8, 1'b1, 1'b1);
    check($sformatf("master_rx_i%0d", m), mrx[0], slave_tx);
    check($sformatf("eot_count_i%0d", m), eot_cnt[m] - e0, 1);
  endtask

  initial begin
    int e0;
    int n;
    reset_n = 1'b0;
    enable  = 1'b1;
    mosi    = 1'b0;
    tx_data = 8'h00;
    tx_load = '0;
    ss_n    = 4'b1110;
    sclk    = 4'b1100;
    for (int i = 0; i < NI; i++) eot_cnt[i] = 0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          if (eot[i]) eot_cnt[i]++;
          if (rx_valid[i]) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL rx_unexpected: inst %0d data %0h, expected no rx_valid", i, rx_data[i]);
            end else begin
              e = exp_q.pop_front();
              check("rx_inst", i, e.inst);
              check("rx_data", rx_data[i], e.data);
            end
          end
        end
      end
    join_none

    wait_clk(6);
    check("rst_miso", miso[0], 1'b0);
    check("rst_oe", miso_oe[0], 1'b0);
    check("rst_rx_valid", rx_valid[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_eot", eot[0], 1'b0);
    check("rst_rx_data", rx_data[0], 8'h00);
    check("rst_tx_ready", tx_ready[0], 1'b1);
    check("rst_underrun", tx_underrun[0], 1'b0);
    check("rst_tx_ready_i2", tx_ready[2], 1'b1);

    // Select held low across reset release: clocks must be ignored
    reset_n = 1'b1;
    wait_clk(10);
    mtx[0] = 8'h96;
    master_xfer(0, 8, 1'b0, 1'b0);
    check("held_select_busy", busy[0], 1'b0);
    ss_n[0] = 1'b1;
    wait_clk(10);

    run_word(0, 8'hA5, 8'h3C);
    for (int m = 1; m < NI; m++) run_word(m, 8'h7E, 8'h81);
    for (int m = 0; m < NI; m++) run_word(m, 8'hB4, 8'h1D);

    // Three-word burst with the host refilling on tx_ready
    mtx[0] = 8'h11; mtx[1] = 8'h22; mtx[2] = 8'h33;
    push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33);
    load(0, 8'hC1);
    e0 = eot_cnt[0];
    fork
      master_xfer(0, 24, 1'b1, 1'b1);
      begin
        for (int k = 1; k < 3; k++) begin
          n = 0;
          while (!tx_ready[0] && n < 2000) begin
            wait_clk(1);
            n++;
          end
          if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL burst_tx_ready_timeout: word %0d, tx_ready never rose", k);
          end else begin
            load(0, (k == 1) ? 8'hC2 : 8'hC3);
          end
        end
      end
    join
    check("burst_rx0", mrx[0], 8'hC1);
    check("burst_rx1", mrx[1], 8'hC2);
    check("burst_rx2", mrx[2], 8'hC3);
    check("burst_eot", eot_cnt[0] - e0, 1);

    // Partial word is discarded, then a full word still works
    mtx[0] = 8'hF0;
    e0 = eot_cnt[0];
    master_xfer(0, 5, 1'b1, 1'b1);
    check("partial_eot", eot_cnt[0] - e0, 1);
    run_word(0, 8'h3A, 8'hC5);

    // Last write to the holding register wins
    load(0, 8'h55);
    check("tx_ready_after_load", tx_ready[0], 1'b0);
    run_word(0, 8'h5A, 8'h4B);

    // Empty holding register sends zeros
    mtx[0] = 8'h66;
    push_exp(0, 8'h66);
    master_xfer(0, 8, 1'b1, 1'b1);
    check("empty_tx_zero", mrx[0], 8'h00);
    check("underrun_set", tx_underrun[0], EXP_UR);
    load(0, 8'h99);
    check("underrun_cleared", tx_underrun[0], 1'b0);

    // Dropping enable mid-transaction does not abort, but blocks the next one
    mtx[0] = 8'hE7;
    push_exp(0, 8'hE7);
    fork
      master_xfer(0, 8, 1'b1, 1'b1);
      begin
        wait_clk(40);
        enable = 1'b0;
      end
    join
    check("enable_drop_rx", mrx[0], 8'h99);
    mtx[0] = 8'h18;
    master_xfer(0, 8, 1'b1, 1'b0);
    enable = 1'b1;
    wait_clk(10);
    run_word(0, 8'h2D, 8'hD2);

    wait_clk(20);
    check("rx_missing", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
